// File: rtl/echo_config_ctrl.sv
// Echo run-time configuration sequencer: enable/attenuation ramping,
// delay-mode stepping with fade-out, delay-line zero sweep and fade-in.
module echo_config_ctrl #(
    parameter int ADDR_BITS    = 15,
    parameter int FADE_SAMPLES = 48,
    parameter int MUTE_SHIFT   = 7,
    parameter int DELAY0       = 2400,
    parameter int DELAY1       = 4800,
    parameter int DELAY2       = 9600,
    parameter int DELAY3       = 14400
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 step,
    input  logic                 sw_enable,
    input  logic                 sw_atten,
    input  logic                 new_sample_ready,
    output logic [ADDR_BITS-1:0] delay_samples,
    output logic [2:0]           atten_shift,
    output logic                 echo_enable,
    output logic                 clr_we,
    output logic [ADDR_BITS-1:0] clr_addr,
    output logic [1:0]           delay_mode,
    output logic                 busy
);

    localparam int CW = (FADE_SAMPLES > 1) ? $clog2(FADE_SAMPLES) : 1;
    localparam logic [CW-1:0]        CNT_MAX  = CW'(FADE_SAMPLES - 1);
    localparam logic [2:0]           MUTE     = 3'(MUTE_SHIFT);
    localparam logic [ADDR_BITS-1:0] ADDR_MAX = {ADDR_BITS{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        FADE_OUT,
        CLEAR
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic                   r_pend;
    logic [ADDR_BITS-1:0]   r_delay;
    logic [2:0]             r_atten;
    logic                   r_en;
    logic                   r_we;
    logic [ADDR_BITS-1:0]   r_addr;
    logic [1:0]             r_mode;
    logic                   r_busy;

    logic                   w_tick;
    logic [2:0]             w_target;
    logic [2:0]             w_ramp;
    logic [2:0]             w_up;
    logic [1:0]             w_mode_nx;

    function automatic logic [ADDR_BITS-1:0] f_delay(input logic [1:0] m);
        logic [ADDR_BITS-1:0] d;
        case (m)
            2'd0:    d = ADDR_BITS'(DELAY0);
            2'd1:    d = ADDR_BITS'(DELAY1);
            2'd2:    d = ADDR_BITS'(DELAY2);
            default: d = ADDR_BITS'(DELAY3);
        endcase
        return d;
    endfunction

    assign w_tick    = new_sample_ready && (r_cnt == CNT_MAX);
    assign w_target  = sw_enable ? (sw_atten ? 3'd2 : 3'd1) : MUTE;
    assign w_ramp    = (r_atten < w_target) ? r_atten + 3'd1 : r_atten - 3'd1;
    assign w_up      = r_atten + 3'd1;
    assign w_mode_nx = r_mode + 2'd1;

    // Controller FSM: owns every output register and the fade counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_delay <= ADDR_BITS'(DELAY0);
            r_atten <= MUTE;
            r_en    <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_mode  <= 2'd0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_pend || step) begin
                        r_state <= FADE_OUT;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_pend  <= 1'b1;
                    end else begin
                        if (new_sample_ready)
                            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                        if (w_tick && (r_atten != w_target)) begin
                            r_atten <= w_ramp;
                            r_en    <= (w_ramp != MUTE);
                        end
                    end
                end
                FADE_OUT: begin
                    r_pend <= r_pend | step;
                    if (r_atten == MUTE) begin
                        r_state <= CLEAR;
                        r_cnt   <= '0;
                        r_we    <= 1'b1;
                        r_addr  <= '0;
                    end else begin
                        if (new_sample_ready)
                            r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
                        if (w_tick) begin
                            r_atten <= w_up;
                            r_en    <= (w_up != MUTE);
                        end
                    end
                end
                CLEAR: begin
                    r_cnt <= '0;
                    r_we  <= 1'b1;
                    if (r_we && (r_addr == ADDR_MAX)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_we    <= 1'b0;
                        r_addr  <= '0;
                        r_pend  <= step;
                        if (r_pend) begin
                            r_mode  <= w_mode_nx;
                            r_delay <= f_delay(w_mode_nx);
                        end
                    end else begin
                        r_pend <= r_pend | step;
                        if (r_we)
                            r_addr <= r_addr + 1'b1;
                    end
                end
                default: begin
                    r_state <= CLEAR;
                    r_busy  <= 1'b1;
                    r_we    <= 1'b0;
                    r_addr  <= '0;
                end
            endcase
        end
    end

    assign delay_samples = r_delay;
    assign atten_shift   = r_atten;
    assign echo_enable   = r_en;
    assign clr_we        = r_we;
    assign clr_addr      = r_addr;
    assign delay_mode    = r_mode;
    assign busy          = r_busy;

endmodule

// File: doc/echo_config_ctrl.md
Name: echo_config_ctrl

Overview:
- Sequences all run-time reconfiguration of the echo effect: enable, attenuation and delay-mode stepping.
- Delay changes go through a click-free fade-out, a zero sweep of the echo delay-line RAM, and a fade-in.
- Sits between the debounced button/switch inputs and the echo datapath, in the clk_100 domain.
- Owns the echo's delay_samples, atten_shift and echo_enable inputs, plus a clear-write port into the delay line.

Parameters:
- ADDR_BITS, 15: delay-line address width; clear sweep covers 0 .. 2^ADDR_BITS-1.
- FADE_SAMPLES, 48: sample strobes per one-step change of atten_shift (48 = 1 ms at 48 kHz).
- MUTE_SHIFT, 7: atten_shift value treated as wet path muted.
- DELAY0, 2400: delay_samples for mode 0.
- DELAY1, 4800: delay_samples for mode 1.
- DELAY2, 9600: delay_samples for mode 2.
- DELAY3, 14400: delay_samples for mode 3.

Ports:
- clk  in  1  system clock (clk_100).
- reset_n  in  1  asynchronous, active-low reset.
- step  in  1  one-cycle pulse from the debounced delay-step button.
- sw_enable  in  1  echo enable switch (level).
- sw_atten  in  1  0 selects 1/2 wet gain, 1 selects 1/4.
- new_sample_ready  in  1  one-cycle audio sample strobe.
- delay_samples  out  ADDR_BITS  delay length to echo.
- atten_shift  out  3  wet-path right shift to echo.
- echo_enable  out  1  wet path enable to echo.
- clr_we  out  1  delay-line zero-write enable.
- clr_addr  out  ADDR_BITS  delay-line zero-write address.
- delay_mode  out  2  current delay mode, for display/LEDs.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- All outputs are registered.
- States: IDLE, FADE_OUT, CLEAR.
- Reset (asynchronous, takes effect immediately, including mid-sweep or mid-fade):
  - state=CLEAR, clr_addr=0, clr_we=0, delay_mode=0, delay_samples=DELAY0, atten_shift=MUTE_SHIFT, echo_enable=0, busy=1.
  - fade counter=0, step_pending=0.
- Target shift T = sw_enable ? (sw_atten ? 2 : 1) : MUTE_SHIFT.
- echo_enable = (atten_shift != MUTE_SHIFT), updated in the same cycle as atten_shift.
- Fade counter:
  - Counts new_sample_ready strobes, 0 .. FADE_SAMPLES-1.
  - A "tick" is the strobe on which the counter wraps to 0.
  - The counter is cleared on every state entry.
- step_pending:
  - Set by step in any state.
  - Cleared when CLEAR completes.
  - One deep: extra steps while pending are dropped.
- IDLE:
  - If step_pending or step: go to FADE_OUT next cycle. Step takes priority over ramping.
  - Otherwise, on each tick move atten_shift one toward T (+1 or -1). Hold when equal.
  - Switch changes therefore ramp one step per FADE_SAMPLES strobes. This is also the fade-in after a clear.
- FADE_OUT:
  - On each tick, atten_shift+1.
  - When atten_shift==MUTE_SHIFT (including on entry), go to CLEAR next cycle with clr_addr=0.
- CLEAR:
  - clr_we=1 every cycle. clr_addr increments by 1 per clk, independent of strobes.
  - On the cycle writing address 2^ADDR_BITS-1:
    - If step_pending: delay_mode += 1, wrapping 3 to 0, and delay_samples loads DELAYn for the new mode.
    - step_pending is cleared.
    - Next state is IDLE; clr_we=0 and clr_addr=0 from the next cycle.
  - atten_shift stays at MUTE_SHIFT throughout CLEAR.
  - After reset, CLEAR runs once with no mode change.
- delay_samples changes only on the final CLEAR cycle, so the echo never reads stale data at the new delay.
- A step arriving during CLEAR after step_pending has already been set is ignored.
- A step arriving in the final CLEAR cycle is retained as pending, and the controller goes IDLE, then FADE_OUT, then another CLEAR.
- new_sample_ready has no effect in CLEAR apart from holding the counter at 0.

Test Plan (ADDR_BITS=4, FADE_SAMPLES=2):
- Reset release -> 16 cycles of clr_we=1, clr_addr 0..15; then busy=0, delay_mode=0, delay_samples=2400, atten_shift=7, echo_enable=0.
- sw_enable=1, sw_atten=0, strobes every 10 clks -> atten_shift steps 7,6,5,4,3,2,1, one step per 2 strobes; echo_enable rises with the first step; holds at 1.
- At atten_shift=1, pulse step -> busy=1; atten_shift climbs to 7 over 12 strobes; 16-cycle clear; delay_samples=4800 and delay_mode=1 on the last clear cycle; then ramps back down to 1.
- Four step presses each fully completed -> delay_mode 1,2,3,0; delay_samples 4800,9600,14400,2400.
- Three step pulses during a single FADE_OUT -> exactly one mode increment.
- reset_n low with clr_addr=9 mid-CLEAR -> outputs take reset values immediately, sweep restarts from 0; delay_mode returns to 0.
- sw_atten toggled 0 to 1 while IDLE at shift 1 -> reaches 2 after 2 strobes, no clear, busy stays 0.
